// File: rtl/muu_pkg.sv
// Shared definitions for the MUU request path: stream geometry, arbiter state
// encodings and a small index-wrapping helper.
package muu_pkg;

  localparam int MUU_STREAM_WIDTH = 128;
  localparam int MUU_USER_BITS    = 3;

  typedef enum logic {
    ST_ARB = 1'b0,
    ST_FWD = 1'b1
  } arb_state_t;

  // Wraps an index that has overshot the port count by at most one lap.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

endpackage

// File: rtl/muu_rr_pick.sv
// Combinational rotating-priority picker: returns the first set request bit
// found searching upward from last+1 with wrap-around.
module muu_rr_pick
  import muu_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = MUU_USER_BITS
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] grant,
  output logic             found
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;

  // Rotating a doubled copy puts port last+1 at bit 0, so a plain
  // lowest-bit-first scan yields round-robin order.
  always_comb begin
    req_dbl = {req, req} >> (int'(last) + 1);
    req_rot = req_dbl[N-1:0];
    grant   = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_rot[i]) begin
        found = 1'b1;
        grant = IDX_W'(rr_wrap(int'(last) + 1 + i, N));
      end
    end
  end

endmodule

// File: rtl/muu_input_arbiter.sv
// Packet-granular round-robin merge of N_PORTS request streams into one
// registered output stream. Define MUU_ARB_PRIO0_EN to make port 0 strict priority.
module muu_input_arbiter
  import muu_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = MUU_STREAM_WIDTH,
  parameter int USER_BITS  = MUU_USER_BITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [N_PORTS-1:0]            s_axis_tvalid,
  input  logic [N_PORTS-1:0]            s_axis_tlast,
  output logic [N_PORTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  output logic [USER_BITS-1:0]          m_axis_tuserid,
  input  logic                          m_axis_tready,
  output logic                          grant_active,
  output logic [USER_BITS-1:0]          grant_port
);

  arb_state_t            state;
  logic [USER_BITS-1:0]  last_port;
  logic [N_PORTS-1:0]    pick_req;
  logic [USER_BITS-1:0]  pick_grant;
  logic                  pick_found;
  logic [USER_BITS-1:0]  arb_grant;
  logic                  arb_found;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_valid;
  logic                  sel_last;
  logic                  out_ready;
  logic                  accept;

`ifdef MUU_ARB_PRIO0_EN
  // Port 0 bypasses the rotation, so the picker only sees ports 1..N-1.
  always_comb begin
    pick_req    = s_axis_tvalid;
    pick_req[0] = 1'b0;
  end
  assign arb_found = s_axis_tvalid[0] | pick_found;
  assign arb_grant = s_axis_tvalid[0] ? '0 : pick_grant;
`else
  assign pick_req  = s_axis_tvalid;
  assign arb_found = pick_found;
  assign arb_grant = pick_grant;
`endif

  muu_rr_pick #(
    .N     (N_PORTS),
    .IDX_W (USER_BITS)
  ) u_pick (
    .req   (pick_req),
    .last  (last_port),
    .grant (pick_grant),
    .found (pick_found)
  );

  // Granted-port mux; only meaningful while forwarding.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (grant_port == USER_BITS'(p)) begin
        sel_data  = s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
        sel_valid = s_axis_tvalid[p];
        sel_last  = s_axis_tlast[p];
      end
    end
  end

  // Ready depends only on state, grant and the output register, never on tvalid.
  assign out_ready = ~m_axis_tvalid | m_axis_tready;
  assign accept    = (state == ST_FWD) & sel_valid & out_ready;

  always_comb begin
    s_axis_tready = '0;
    if (state == ST_FWD) begin
      for (int p = 0; p < N_PORTS; p++) begin
        s_axis_tready[p] = (grant_port == USER_BITS'(p)) & out_ready;
      end
    end
  end

  // Grant is held for the whole packet; it only moves after a tlast word is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_ARB;
      last_port    <= USER_BITS'(N_PORTS - 1);
      grant_port   <= '0;
      grant_active <= 1'b0;
    end else begin
      case (state)
        ST_ARB: begin
          if (arb_found) begin
            grant_port   <= arb_grant;
            last_port    <= arb_grant;
            grant_active <= 1'b1;
            state        <= ST_FWD;
          end
        end
        ST_FWD: begin
          if (accept && sel_last) begin
            grant_active <= 1'b0;
            state        <= ST_ARB;
          end
        end
        default: begin
          grant_active <= 1'b0;
          state        <= ST_ARB;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid  <= 1'b0;
      m_axis_tlast   <= 1'b0;
      m_axis_tdata   <= '0;
      m_axis_tuserid <= '0;
    end else if (accept) begin
      m_axis_tvalid  <= 1'b1;
      m_axis_tlast   <= sel_last;
      m_axis_tdata   <= sel_data;
      m_axis_tuserid <= grant_port;
    end else if (m_axis_tready) begin
      m_axis_tvalid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_muu_input_arbiter.sv
// Self-checking bench for muu_input_arbiter: cycle vector table plus
// hand-written sequences for backpressure, stalls, reset and priority.
module tb_muu_input_arbiter;

  localparam int NP = 4;
  localparam int DW = 128;

  logic           clk = 1'b0;
  logic           rst;
  logic [NP*DW-1:0] s_tdata;
  logic [NP-1:0]  s_tvalid;
  logic [NP-1:0]  s_tlast;
  logic [NP-1:0]  s_tready;
  logic [DW-1:0]  m_tdata;
  logic           m_tvalid;
  logic           m_tlast;
  logic [2:0]     m_tuserid;
  logic           m_tready;
  logic           grant_active;
  logic [2:0]     grant_port;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic [3:0] lst;
    logic [7:0] dat;
    logic       mrdy;
    logic [3:0] e_sready;
    logic       e_mvalid;
    logic       e_mlast;
    logic [2:0] e_user;
    logic [7:0] e_dat;
    logic       e_gact;
    logic [2:0] e_gport;
  } vec_t;

  typedef struct packed {
    logic [2:0]   user;
    logic [127:0] data;
    logic         last;
  } word_t;

  vec_t  vecs[$];
  word_t out_q[$];
  word_t exp_q[$];

  int src_len[NP];
  int src_start[NP];
  int src_base[NP];
  int stall_port;
  int stall_word;
  int stall_cycles;
  bit toggle_rdy;

  muu_input_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis_tdata   (s_tdata),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tlast   (s_tlast),
    .s_axis_tready  (s_tready),
    .m_axis_tdata   (m_tdata),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tlast   (m_tlast),
    .m_axis_tuserid (m_tuserid),
    .m_axis_tready  (m_tready),
    .grant_active   (grant_active),
    .grant_port     (grant_port)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [3:0] vld, input logic [3:0] lst,
                              input logic [7:0] dat, input logic mrdy, input logic [3:0] e_sready,
                              input logic e_mvalid, input logic e_mlast, input logic [2:0] e_user,
                              input logic [7:0] e_dat, input logic e_gact, input logic [2:0] e_gport);
    vec_t v;
    v.rst = r; v.vld = vld; v.lst = lst; v.dat = dat; v.mrdy = mrdy;
    v.e_sready = e_sready; v.e_mvalid = e_mvalid; v.e_mlast = e_mlast;
    v.e_user = e_user; v.e_dat = e_dat; v.e_gact = e_gact; v.e_gport = e_gport;
    return v;
  endfunction

  function automatic logic [127:0] port_word(input int p, input logic [7:0] dat);
    return {117'b0, 3'(p), dat};
  endfunction

  function automatic word_t mk_word(input int p, input logic [7:0] dat, input logic last);
    word_t w;
    w.user = 3'(p);
    w.data = port_word(p, dat);
    w.last = last;
    return w;
  endfunction

  task automatic cmp(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    s_tvalid = '0;
    s_tlast = '0;
    s_tdata = '0;
    m_tready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    rst = v.rst;
    s_tvalid = v.vld;
    s_tlast = v.lst;
    m_tready = v.mrdy;
    for (int p = 0; p < NP; p++) s_tdata[p*DW +: DW] = port_word(p, v.dat);
  endtask

  task automatic checkOutput(input int i, input vec_t v);
    cmp($sformatf("row%0d sready", i), s_tready, v.e_sready);
    cmp($sformatf("row%0d mvalid", i), m_tvalid, v.e_mvalid);
    cmp($sformatf("row%0d gact", i), grant_active, v.e_gact);
    cmp($sformatf("row%0d gport", i), grant_port, v.e_gport);
    if (v.e_mvalid) begin
      cmp($sformatf("row%0d mdata", i), m_tdata, {117'b0, v.e_user, v.e_dat});
      cmp($sformatf("row%0d mlast", i), m_tlast, v.e_mlast);
      cmp($sformatf("row%0d muser", i), m_tuserid, v.e_user);
    end
  endtask

  // Source models hold each word until it is handshaken; sink records output words.
  task automatic runSources(input string name, input int max_cycles);
    int idx[NP];
    int stall_left;
    bit done;
    bit m_hs;
    logic [NP-1:0] s_hs;
    word_t w;
    idx = '{default: 0};
    stall_left = stall_cycles;
    done = 1'b0;
    out_q.delete();
    for (int cyc = 0; cyc < max_cycles && !done; cyc++) begin
      for (int p = 0; p < NP; p++) begin
        s_tvalid[p] = (cyc >= src_start[p]) && (idx[p] < src_len[p]);
        if (p == stall_port && idx[p] == stall_word && stall_left > 0 && s_tvalid[p]) begin
          s_tvalid[p] = 1'b0;
          stall_left--;
        end
        s_tlast[p] = (idx[p] == src_len[p] - 1);
        s_tdata[p*DW +: DW] = port_word(p, 8'(src_base[p] + idx[p]));
      end
      m_tready = toggle_rdy ? (cyc % 2 == 0) : 1'b1;
      #1;
      cmp($sformatf("%s ready rules c%0d", name, cyc),
          {159'b0, (!$onehot0(s_tready)) || (m_tvalid && !m_tready && (|s_tready))}, 160'b0);
      s_hs = s_tvalid & s_tready;
      m_hs = m_tvalid & m_tready;
      if (m_hs) begin
        w.user = m_tuserid;
        w.data = m_tdata;
        w.last = m_tlast;
        out_q.push_back(w);
      end
      @(posedge clk);
      for (int p = 0; p < NP; p++) if (s_hs[p]) idx[p]++;
      @(negedge clk);
      done = !m_tvalid;
      for (int p = 0; p < NP; p++) if (idx[p] < src_len[p]) done = 1'b0;
    end
    cmp({name, " finished in budget"}, {159'b0, done}, 160'd1);
    s_tvalid = '0;
    s_tlast = '0;
  endtask

  task automatic compareQueues(input string name);
    cmp({name, " word count"}, out_q.size(), exp_q.size());
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      cmp($sformatf("%s word%0d", name, i), out_q[i], exp_q[i]);
  endtask

  initial begin
    int gq[$];
    int ge[4];

    // Single 3-word packet on port 2, then an idle reset.
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 8'hA0, 1, 4'b0000, 0, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 8'hA0, 1, 4'b0100, 0, 0, 0, 8'h00, 1, 2));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 8'hA1, 1, 4'b0100, 1, 0, 2, 8'hA0, 1, 2));
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 8'hA2, 1, 4'b0100, 1, 0, 2, 8'hA1, 1, 2));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 1, 1, 2, 8'hA2, 0, 2));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 0, 0, 0, 8'h00, 0, 2));
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 0, 0, 0, 8'h00, 0, 2));
`ifndef MUU_ARB_PRIO0_EN
    // Ports 0,1,3 contend with 2-word packets: round-robin 0,1,3,0,1,3.
    vecs.push_back(mk(0, 4'b1011, 4'b0000, 8'h10, 1, 4'b0000, 0, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 4'b1011, 4'b0000, 8'h10, 1, 4'b0001, 0, 0, 0, 8'h00, 1, 0));
    vecs.push_back(mk(0, 4'b1011, 4'b1111, 8'h11, 1, 4'b0001, 1, 0, 0, 8'h10, 1, 0));
    vecs.push_back(mk(0, 4'b1011, 4'b0000, 8'h20, 1, 4'b0000, 1, 1, 0, 8'h11, 0, 0));
    vecs.push_back(mk(0, 4'b1011, 4'b0000, 8'h20, 1, 4'b0010, 0, 0, 0, 8'h00, 1, 1));
    vecs.push_back(mk(0, 4'b1011, 4'b1111, 8'h21, 1, 4'b0010, 1, 0, 1, 8'h20, 1, 1));
    vecs.push_back(mk(0, 4'b1011, 4'b0000, 8'h30, 1, 4'b0000, 1, 1, 1, 8'h21, 0, 1));
    vecs.push_back(mk(0, 4'b1011, 4'b0000, 8'h30, 1, 4'b1000, 0, 0, 0, 8'h00, 1, 3));
    vecs.push_back(mk(0, 4'b1011, 4'b1111, 8'h31, 1, 4'b1000, 1, 0, 3, 8'h30, 1, 3));
    vecs.push_back(mk(0, 4'b1011, 4'b0000, 8'h40, 1, 4'b0000, 1, 1, 3, 8'h31, 0, 3));
    vecs.push_back(mk(0, 4'b1011, 4'b0000, 8'h40, 1, 4'b0001, 0, 0, 0, 8'h00, 1, 0));
    vecs.push_back(mk(0, 4'b1011, 4'b1111, 8'h41, 1, 4'b0001, 1, 0, 0, 8'h40, 1, 0));
    vecs.push_back(mk(0, 4'b1011, 4'b0000, 8'h50, 1, 4'b0000, 1, 1, 0, 8'h41, 0, 0));
    vecs.push_back(mk(0, 4'b1011, 4'b0000, 8'h50, 1, 4'b0010, 0, 0, 0, 8'h00, 1, 1));
    vecs.push_back(mk(0, 4'b1011, 4'b1111, 8'h51, 1, 4'b0010, 1, 0, 1, 8'h50, 1, 1));
    vecs.push_back(mk(0, 4'b1011, 4'b0000, 8'h60, 1, 4'b0000, 1, 1, 1, 8'h51, 0, 1));
    vecs.push_back(mk(0, 4'b1011, 4'b0000, 8'h60, 1, 4'b1000, 0, 0, 0, 8'h00, 1, 3));
    vecs.push_back(mk(0, 4'b1011, 4'b1111, 8'h61, 1, 4'b1000, 1, 0, 3, 8'h60, 1, 3));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 1, 1, 3, 8'h61, 0, 3));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 0, 0, 0, 8'h00, 0, 3));
`endif

    stall_port = -1; stall_word = 0; stall_cycles = 0; toggle_rdy = 1'b0;
    doReset();
    $display("[TB] reset values");
    cmp("reset mvalid", m_tvalid, 0);
    cmp("reset mlast", m_tlast, 0);
    cmp("reset mdata", m_tdata, 0);
    cmp("reset muser", m_tuserid, 0);
    cmp("reset sready", s_tready, 0);
    cmp("reset gact", grant_active, 0);
    cmp("reset gport", grant_port, 0);

    $display("[TB] vector table, %0d rows", vecs.size());
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput(i, vecs[i]);
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b0;

    $display("[TB] 4-word packet with toggling m_axis_tready");
    doReset();
    src_len = '{0, 4, 0, 0}; src_start = '{0, 0, 0, 0}; src_base = '{0, 8'h60, 0, 0};
    stall_port = -1; toggle_rdy = 1'b1;
    runSources("toggle", 60);
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(mk_word(1, 8'(8'h60 + k), k == 3));
    compareQueues("toggle");

    $display("[TB] grant held through stall while port 2 waits");
    doReset();
    src_len = '{0, 4, 2, 0}; src_start = '{0, 0, 3, 0}; src_base = '{0, 8'hB0, 8'hC0, 0};
    stall_port = 1; stall_word = 2; stall_cycles = 3; toggle_rdy = 1'b0;
    runSources("stall", 60);
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(mk_word(1, 8'(8'hB0 + k), k == 3));
    for (int k = 0; k < 2; k++) exp_q.push_back(mk_word(2, 8'(8'hC0 + k), k == 1));
    compareQueues("stall");
    stall_port = -1;

    $display("[TB] reset in the middle of a packet");
    doReset();
    s_tvalid = 4'b1000; s_tlast = 4'b0000; m_tready = 1'b1;
    s_tdata[3*DW +: DW] = port_word(3, 8'h70);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    s_tdata[3*DW +: DW] = port_word(3, 8'h71);
    rst = 1'b1;
    #1;
    cmp("midrst pre mvalid", m_tvalid, 1);
    cmp("midrst pre mdata", m_tdata, port_word(3, 8'h70));
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    s_tvalid = 4'b1001; s_tlast = 4'b1001;
    s_tdata[0 +: DW] = port_word(0, 8'h80);
    #1;
    cmp("midrst mvalid", m_tvalid, 0);
    cmp("midrst sready", s_tready, 0);
    cmp("midrst gact", grant_active, 0);
    @(posedge clk); @(negedge clk);
    #1;
    cmp("midrst regrant gact", grant_active, 1);
    cmp("midrst regrant gport", grant_port, 0);
    cmp("midrst regrant sready", s_tready, 4'b0001);
    @(posedge clk); @(negedge clk);
    s_tvalid = 4'b0000;
    #1;
    cmp("midrst out mvalid", m_tvalid, 1);
    cmp("midrst out mdata", m_tdata, port_word(0, 8'h80));
    cmp("midrst out muser", m_tuserid, 0);
    cmp("midrst out mlast", m_tlast, 1);
    @(posedge clk); @(negedge clk);

    $display("[TB] ports 0 and 2 contending with single-word packets");
    doReset();
    s_tvalid = 4'b0101; s_tlast = 4'b1111; m_tready = 1'b1;
    for (int p = 0; p < NP; p++) s_tdata[p*DW +: DW] = port_word(p, 8'h90);
    gq.delete();
    for (int cyc = 0; cyc < 8; cyc++) begin
      #1;
      if (grant_active) gq.push_back(int'(grant_port));
      @(posedge clk); @(negedge clk);
    end
    s_tvalid = '0;
`ifdef MUU_ARB_PRIO0_EN
    ge = '{0, 0, 0, 0};
`else
    ge = '{0, 2, 0, 2};
`endif
    cmp("pair grant count", gq.size(), 4);
    for (int i = 0; i < gq.size() && i < 4; i++)
      cmp($sformatf("pair grant%0d", i), gq[i], ge[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
